// File: rtl/timer_pkg.sv
// Shared timer/PWM types: mode encoding and default counter width.
// Imported by the prescaler and the multi-channel top.
package timer_pkg;

  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_INT     = 2'b01,
    MODE_PWM     = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

endpackage

// File: rtl/timer_prescaler.sv
// Shared prescaler: emits one tick every prescaler+1 cycles.
// clear holds the divider at zero and suppresses the tick.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [CNT_W-1:0] prescaler,
  output logic             tick
);

  logic [CNT_W-1:0] pres_cnt_q;
  logic [CNT_W-1:0] pres_cnt_d;

  // Tick on reaching (or passing) the limit, then restart from 0.
  always_comb begin
    tick       = !clear && (pres_cnt_q >= prescaler);
    pres_cnt_d = pres_cnt_q + CNT_W'(1);
    if (clear || tick) pres_cnt_d = '0;
  end

  // Divider state.
  always_ff @(posedge clk) begin
    if (reset) pres_cnt_q <= '0;
    else       pres_cnt_q <= pres_cnt_d;
  end

endmodule

// File: rtl/timer_pwm_multi.sv
// Multi-channel timer/PWM: shared period counter, shadowed compares.
// Optional one-shot mode 11 enabled by TIMER_PWM_ONESHOT_EN.
module timer_pwm_multi
  import timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int N_CH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic [CNT_W-1:0]      prescaler,
  input  logic [CNT_W-1:0]      max_count,
  input  logic [N_CH*CNT_W-1:0] compare,
  input  logic                  int_clear,
  output logic                  timer_int,
  output logic                  period_end,
  output logic [N_CH-1:0]       pwm_out,
  output logic [CNT_W-1:0]      count_out
);

  mode_e            mode_cur;
  mode_e            mode_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] max_sh_q, max_sh_d;
  logic [CNT_W-1:0] cmp_sh_q [N_CH];
  logic [CNT_W-1:0] cmp_sh_d [N_CH];
  logic [N_CH-1:0]  pwm_q, pwm_d;
  logic             pe_q, pe_d;
  logic             int_q, int_d;
  logic             mode_chg, run, active;
  logic             tick, wrap, reload;
  logic             is_pwm, int_set;

  assign mode_cur = mode_e'(mode);

  timer_prescaler #(.CNT_W(CNT_W)) u_pres (
    .clk       (clk),
    .reset     (reset),
    .clear     (!active),
    .prescaler (prescaler),
    .tick      (tick)
  );

`ifdef TIMER_PWM_ONESHOT_EN
  logic done_q, done_d;

  // One-shot halts after its single wrap until the mode changes.
  always_comb begin
    run = (mode_cur == MODE_INT) || (mode_cur == MODE_PWM) ||
          ((mode_cur == MODE_ONESHOT) && !done_q);
    done_d = mode_chg ? 1'b0 :
             (done_q || (wrap && (mode_cur == MODE_ONESHOT)));
  end

  // One-shot completion flag.
  always_ff @(posedge clk) begin
    if (reset) done_q <= 1'b0;
    else       done_q <= done_d;
  end
`else
  // Mode 11 without the one-shot feature is identical to off.
  always_comb begin
    run = (mode_cur == MODE_INT) || (mode_cur == MODE_PWM);
  end
`endif

  // Period counter, wrap detection, shadow reload and interrupt.
  always_comb begin
    mode_chg = (mode_cur != mode_q);
    active   = run && !mode_chg;
    wrap     = active && tick && (count_q >= max_sh_q);
    reload   = mode_chg || wrap;
    is_pwm   = active && (mode_cur == MODE_PWM);
    count_d  = count_q;
    if (!active)   count_d = '0;
    else if (wrap) count_d = '0;
    else if (tick) count_d = count_q + CNT_W'(1);
    max_sh_d = reload ? max_count : max_sh_q;
    pe_d     = wrap;
    int_set  = wrap && (mode_cur != MODE_PWM);
    int_d    = int_q;
    if (int_set)        int_d = 1'b1;
    else if (int_clear) int_d = 1'b0;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign cmp_sh_d[i] = reload ? compare[i*CNT_W +: CNT_W]
                                : cmp_sh_q[i];
    assign pwm_d[i] = is_pwm && (count_d < cmp_sh_d[i]);

    // Per-channel compare shadow.
    always_ff @(posedge clk) begin
      if (reset) cmp_sh_q[i] <= '0;
      else       cmp_sh_q[i] <= cmp_sh_d[i];
    end
  end

  // Shared timer state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q   <= MODE_OFF;
      count_q  <= '0;
      max_sh_q <= '0;
      pwm_q    <= '0;
      pe_q     <= 1'b0;
      int_q    <= 1'b0;
    end else begin
      mode_q   <= mode_cur;
      count_q  <= count_d;
      max_sh_q <= max_sh_d;
      pwm_q    <= pwm_d;
      pe_q     <= pe_d;
      int_q    <= int_d;
    end
  end

  assign timer_int  = int_q;
  assign period_end = pe_q;
  assign pwm_out    = pwm_q;
  assign count_out  = count_q;

endmodule

// File: tb/tb_timer_pwm_multi.sv
// Self-checking bench for timer_pwm_multi with a behavioural model.
// Directed scenarios followed by randomized traffic.
module tb_timer_pwm_multi;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     mode;
  logic [W-1:0]   prescaler;
  logic [W-1:0]   max_count;
  logic [N*W-1:0] compare;
  logic           int_clear;
  logic           timer_int;
  logic           period_end;
  logic [N-1:0]   pwm_out;
  logic [W-1:0]   count_out;

  int n_run  = 0;
  int n_fail = 0;

  timer_pwm_multi #(.CNT_W(W), .N_CH(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .prescaler  (prescaler),
    .max_count  (max_count),
    .compare    (compare),
    .int_clear  (int_clear),
    .timer_int  (timer_int),
    .period_end (period_end),
    .pwm_out    (pwm_out),
    .count_out  (count_out)
  );

  always #5 clk = ~clk;

  // Reference model: spec rules applied once per clock.
  logic [1:0]   m_prev;
  logic [W-1:0] m_pres, m_count, m_max;
  logic [W-1:0] m_cmp [N];
  logic         m_int, m_pe, m_done;
  logic [N-1:0] m_pwm;
  bit           m_run, m_set;
`ifdef TIMER_PWM_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  always @(posedge clk) begin
    m_set = 1'b0;
    if (reset) begin
      m_prev = 0; m_pres = 0; m_count = 0; m_max = 0;
      m_int = 0; m_pe = 0; m_pwm = 0; m_done = 0;
      for (int i = 0; i < N; i++) m_cmp[i] = 0;
    end else if (mode != m_prev) begin
      m_pres = 0; m_count = 0; m_pwm = 0; m_pe = 0; m_done = 0;
      m_max = max_count;
      for (int i = 0; i < N; i++) m_cmp[i] = compare[i*W +: W];
      m_prev = mode;
      if (int_clear) m_int = 0;
    end else begin
      m_run = (mode == 2'b01) || (mode == 2'b10) ||
              (ONESHOT && mode == 2'b11 && !m_done);
      m_pe = 0;
      if (!m_run) begin
        m_pres = 0; m_count = 0; m_pwm = 0;
      end else begin
        if (m_pres >= prescaler) begin
          m_pres = 0;
          if (m_count >= m_max) begin
            m_count = 0;
            m_pe = 1;
            m_max = max_count;
            for (int i = 0; i < N; i++) m_cmp[i] = compare[i*W +: W];
            if (mode != 2'b10) m_set = 1;
            if (mode == 2'b11) m_done = 1;
          end else begin
            m_count = m_count + 1;
          end
        end else begin
          m_pres = m_pres + 1;
        end
        for (int i = 0; i < N; i++)
          m_pwm[i] = (mode == 2'b10) && (m_count < m_cmp[i]);
      end
      if (m_set) m_int = 1;
      else if (int_clear) m_int = 0;
    end
  end

  task automatic test_reset();
    mode = 2'b10; prescaler = 0; max_count = 9;
    compare = {32'd12, 32'd9, 32'd3, 32'd0};
    repeat (50) begin
      @(negedge clk);
      n_run++;
      if ({timer_int, period_end, pwm_out, count_out} !==
          {m_int, m_pe, m_pwm, m_count}) begin
        n_fail++;
        $display("FAIL reset_pre got %b %b %b %0d want %b %b %b %0d",
                 timer_int, period_end, pwm_out, count_out,
                 m_int, m_pe, m_pwm, m_count);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_run++;
    if ({timer_int, period_end, pwm_out, count_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_zero got %b %b %b %0d want all 0",
               timer_int, period_end, pwm_out, count_out);
    end
  endtask

  task automatic test_int();
    int last, npulse, t;
    bit ok;
    mode = 2'b01; prescaler = 1; max_count = 3;
    last = -1; npulse = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (period_end) begin
        if (last >= 0) begin
          n_run++;
          if (c - last != 8) begin
            n_fail++;
            $display("FAIL int_period got %0d want 8", c - last);
          end
        end
        last = c; npulse++;
        n_run++;
        if (timer_int !== 1'b1) begin
          n_fail++;
          $display("FAIL int_set got %b want 1", timer_int);
        end
      end
    end
    n_run++;
    if (npulse < 4) begin
      n_fail++;
      $display("FAIL int_pulses got %0d want >=4", npulse);
    end
    t = 0; ok = 0;
    while (t < 20 && !ok) begin
      if (m_count == 3 && m_pres == 1) ok = 1;
      else begin @(negedge clk); t++; end
    end
    n_run++;
    if (!ok) begin
      n_fail++;
      $display("FAIL int_wait got timeout want wrap");
    end
    int_clear = 1'b1;
    @(negedge clk);
    int_clear = 1'b0;
    n_run++;
    if ({timer_int, period_end} !== 2'b11) begin
      n_fail++;
      $display("FAIL int_clr_wrap got %b%b want 11",
               timer_int, period_end);
    end
    int_clear = 1'b1;
    @(negedge clk);
    int_clear = 1'b0;
    n_run++;
    if (timer_int !== 1'b0) begin
      n_fail++;
      $display("FAIL int_clr got %b want 0", timer_int);
    end
  endtask

  task automatic test_pwm_duty();
    int hi [N];
    int exp_hi [N];
    exp_hi = '{0, 3, 9, 10};
    for (int i = 0; i < N; i++) hi[i] = 0;
    mode = 2'b10; prescaler = 0; max_count = 9;
    compare = {32'd12, 32'd9, 32'd3, 32'd0};
    repeat (2) @(negedge clk);
    repeat (10) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) hi[i] += int'(pwm_out[i]);
    end
    for (int i = 0; i < N; i++) begin
      n_run++;
      if (hi[i] != exp_hi[i]) begin
        n_fail++;
        $display("FAIL duty_ch%0d got %0d want %0d", i, hi[i], exp_hi[i]);
      end
    end
  endtask

  task automatic test_shadow();
    int t;
    int exp_cnt [10];
    bit exp_p1 [10];
    exp_cnt = '{6, 7, 8, 9, 0, 1, 2, 3, 4, 0};
    exp_p1  = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    t = 0;
    while (t < 30 && m_count != 5) begin @(negedge clk); t++; end
    n_run++;
    if (m_count != 5) begin
      n_fail++;
      $display("FAIL shadow_wait got %0d want 5", m_count);
    end
    compare[63:32] = 32'd7;
    max_count = 4;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_run++;
      if (count_out !== W'(exp_cnt[c]) || pwm_out[1] !== exp_p1[c] ||
          period_end !== (exp_cnt[c] == 0)) begin
        n_fail++;
        $display("FAIL shadow_c%0d got %0d %b %b want %0d %b %b", c,
                 count_out, pwm_out[1], period_end,
                 exp_cnt[c], exp_p1[c], exp_cnt[c] == 0);
      end
    end
  endtask

  task automatic test_mode_switch();
    int t;
    t = 0;
    while (t < 20 && m_count != 2) begin @(negedge clk); t++; end
    mode = 2'b01;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_run++;
      if (count_out !== W'(c) || pwm_out !== '0) begin
        n_fail++;
        $display("FAIL switch_c%0d got %0d %b want %0d 0000",
                 c, count_out, pwm_out, c);
      end
    end
  endtask

  task automatic test_oneshot();
    int npe, at;
    mode = 2'b00; prescaler = 0; max_count = 5;
    int_clear = 1'b1;
    @(negedge clk);
    int_clear = 1'b0;
    mode = 2'b11;
    npe = 0; at = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (period_end) begin npe++; at = c; end
      n_run++;
      if ({timer_int, period_end, pwm_out, count_out} !==
          {m_int, m_pe, m_pwm, m_count}) begin
        n_fail++;
        $display("FAIL oneshot_model got %b %b %0d want %b %b %0d",
                 timer_int, period_end, count_out,
                 m_int, m_pe, m_count);
      end
    end
    n_run++;
    if (npe != (ONESHOT ? 1 : 0) || count_out !== '0 ||
        timer_int !== ONESHOT || (ONESHOT && at != 6)) begin
      n_fail++;
      $display("FAIL oneshot got pe=%0d at=%0d int=%b cnt=%0d want %0d 6 %b 0",
               npe, at, timer_int, count_out, ONESHOT ? 1 : 0, ONESHOT);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(299) == 0);
      int_clear = ($urandom_range(7) == 0);
      if ($urandom_range(19) == 0) mode = 2'($urandom_range(3));
      if ($urandom_range(9) == 0) prescaler = W'($urandom_range(3));
      if ($urandom_range(9) == 0) max_count = W'($urandom_range(7));
      if ($urandom_range(4) == 0)
        compare[$urandom_range(N-1)*W +: W] = W'($urandom_range(9));
      @(negedge clk);
      n_run++;
      if ({timer_int, period_end, pwm_out, count_out} !==
          {m_int, m_pe, m_pwm, m_count}) begin
        n_fail++;
        $display("FAIL random_c%0d got %b %b %b %0d want %b %b %b %0d", c,
                 timer_int, period_end, pwm_out, count_out,
                 m_int, m_pe, m_pwm, m_count);
      end
    end
    reset = 1'b0;
    int_clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mode = 2'b00; prescaler = 0; max_count = 0;
    compare = '0; int_clear = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_int();
    test_pwm_duty();
    test_shadow();
    test_mode_switch();
    test_oneshot();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_pwm_multi.md
# timer_pwm_multi

Parametrised multi-channel successor to the single-channel timer/PWM block. One shared prescaler and period counter drive N_CH independent edge-aligned PWM compare channels, plus a periodic interrupt mode. Compare and period values are shadowed and take effect only at period boundaries, so PWM updates are glitch-free. The block sits behind the peripheral register interface and drives the elevator motor/door PWM pins and the timer interrupt line.

## Interface
- CNT_W, 32, width of prescaler, period and compare values
- N_CH, 4, number of PWM compare channels (1..8)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mode  in  2  00 off, 01 periodic interrupt, 10 PWM, 11 one-shot (macro-dependent)
- prescaler  in  CNT_W  tick every prescaler+1 clk cycles
- max_count  in  CNT_W  period = max_count+1 ticks
- compare  in  N_CH*CNT_W  channel i compare at bits [i*CNT_W +: CNT_W]
- int_clear  in  1  single-cycle clear of timer_int
- timer_int  out  1  sticky interrupt flag
- period_end  out  1  one-cycle pulse on counter wrap
- pwm_out  out  N_CH  registered PWM outputs
- count_out  out  CNT_W  current period count

## Operation
- Reset (synchronous): pres_cnt, count, max_sh, cmp_sh[*], prev_mode, timer_int, period_end, pwm_out all 0.
- Mode change (mode != prev_mode): pres_cnt=0, count=0, pwm_out=0, period_end=0, shadows reload from inputs, prev_mode=mode; no counting that cycle. timer_int retained.
- Mode 00: counters held at 0, pwm_out=0, period_end=0.
- Prescaler: tick when pres_cnt >= prescaler, then pres_cnt=0; else pres_cnt+1. prescaler=0 -> tick every cycle. Lowering prescaler below pres_cnt ticks on next cycle.
- Counter, on tick: if count >= max_sh -> count=0, period_end=1, shadows reload; else count+1. Lowering max_count takes effect only after the current period.
- Mode 01: period_end sets timer_int. pwm_out=0.
- Mode 10: pwm_out[i] = (next count < next cmp_sh[i]), registered, so pwm_out[i] always equals (count_out < cmp_sh[i]). cmp=0 -> constant low; cmp > max_sh -> constant high. timer_int untouched by wraps.
- int_clear and a timer_int set in the same cycle: set wins.
- All arithmetic unsigned, CNT_W bits; count never exceeds max_sh, so no overflow wrap.

## Timing
- Period in mode 01/10: (max_sh+1)*(prescaler+1) clk cycles.
- First tick after entering a mode: prescaler+1 cycles after the mode-change cycle.
- period_end and timer_int assert on the same edge that count goes to 0.
- Compare/max writes become active on the first count=0 after the write, never mid-period.
- All outputs registered; no combinational input-to-output paths.

## Configuration
- TIMER_PWM_ONESHOT_EN defined: mode 11 counts exactly one period, sets timer_int and pulses period_end at wrap, then halts with count=0 and pres_cnt=0 until mode changes. Re-arm by leaving 11 and returning. pwm_out=0 in this mode.
- Macro undefined: mode 11 behaves exactly as mode 00.

## Structure
- Package timer_pkg: mode constants MODE_OFF/MODE_INT/MODE_PWM/MODE_ONESHOT, mode typedef, default CNT_W.
- Sub-module timer_prescaler (CNT_W param; clk, reset, clear, prescaler in; tick out) holds pres_cnt. Compare channels built with a generate loop in the top.

## Test plan
- Reset mid-PWM: mode=10, run 50 cycles, pulse reset -> next cycle all outputs 0, count_out=0.
- Mode 01, prescaler=1, max_count=3 -> period_end/timer_int set every 8 cycles; int_clear coincident with a wrap leaves timer_int=1.
- Mode 10, prescaler=0, max_count=9, compare={0,3,9,12} -> duty 0/10, 3/10, 9/10, 10/10 on pwm_out[0..3].
- Change compare[1] 3->7 and max_count 9->4 at count=5 -> current period finishes at 9 with old duty; next period 5 cycles, pwm_out[1] high 5/5.
- Switch mode 10->01 mid-period -> one cycle with count=0, pwm_out=0, then interrupt counting from 0.
- With TIMER_PWM_ONESHOT_EN, mode 11, prescaler=0, max_count=5 -> single period_end after 6 counting cycles, count holds 0; without macro, count stays 0, no interrupt.
